// File: rtl/output_drain.sv
// Read-side sequencer for the per-column output memories: fetches rows in
// parallel, buffers each one, then streams it column by column on valid/ready.
module output_drain #(
    parameter  int WIDTH_HEIGHT = 4,
    parameter  int ADDR_W       = 8,
    parameter  int DATA_W       = 16,
    localparam int COL_W        = $clog2(WIDTH_HEIGHT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [ADDR_W:0]                num_rows,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH_HEIGHT-1:0]        mem_rd_en,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] mem_rd_addr,
    input  logic [WIDTH_HEIGHT*DATA_W-1:0] mem_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [COL_W-1:0]               out_col,
    output logic                           out_last,
    output logic [2:0]                     dbg_state
);

    // Stream handshake: a word transfers on any rising edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 the word,
    // column and last flag hold, and out_valid never drops without a transfer.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH_HEIGHT - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_num_rows;
    logic [ADDR_W:0]     r_row;
    logic [COL_W-1:0]    r_col;
    logic [DATA_W-1:0]   r_buf [WIDTH_HEIGHT];
    logic                r_busy;
    logic                r_done;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;

    logic [ADDR_W:0]     w_row_inc;
    logic [COL_W-1:0]    w_col_inc;
    logic                w_last_row;

    assign w_row_inc  = r_row + (ADDR_W+1)'(1);
    assign w_col_inc  = r_col + COL_W'(1);
    assign w_last_row = (r_row == r_num_rows - (ADDR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_num_rows  <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (num_rows != '0) begin
                            r_base     <= base_addr;
                            r_num_rows <= num_rows;
                            r_row      <= '0;
                            r_rd_en    <= 1'b1;
                            r_rd_addr  <= base_addr;
                            r_busy     <= 1'b1;
                            r_state    <= S_READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                        r_buf[i] <= mem_rd_data[i*DATA_W +: DATA_W];
                    end
                    // Column 0 comes straight off the read bus; it can never be
                    // the last column since the array is at least two wide.
                    r_out_data  <= mem_rd_data[0 +: DATA_W];
                    r_col       <= '0;
                    r_out_last  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_col == LAST_COL) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (w_last_row) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_row     <= w_row_inc;
                                r_rd_en   <= 1'b1;
                                r_rd_addr <= r_base + w_row_inc[ADDR_W-1:0];
                                r_state   <= S_READ;
                            end
                        end else begin
                            r_col      <= w_col_inc;
                            r_out_data <= r_buf[w_col_inc];
                            r_out_last <= (w_col_inc == LAST_COL) && w_last_row;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_rd_en   = {WIDTH_HEIGHT{r_rd_en}};
    assign mem_rd_addr = {WIDTH_HEIGHT{r_rd_addr}};
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_col     = r_col;
    assign out_last    = r_out_last;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_output_drain.sv
// Bench for output_drain: memory model, scoreboard of expected words and read
// addresses, and one task per scenario.
module tb_output_drain;

    localparam int WH = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 2;
    localparam int EW = DW + CW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       num_rows = '0;
    logic              busy;
    logic              done;
    logic [WH-1:0]     mem_rd_en;
    logic [WH*AW-1:0]  mem_rd_addr;
    logic [WH*DW-1:0]  mem_rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_col;
    logic              out_last;
    logic [2:0]        dbg_state;

    output_drain #(.WIDTH_HEIGHT(WH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last), .dbg_state(dbg_state)
    );

    // Clock / reset-independent cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Column memories: column i at address a holds 0x1000 + i*0x100 + a.
    // Unread cycles return filler so late or early capture is visible.
    function automatic logic [DW-1:0] mem_val(input int col, input logic [AW-1:0] a);
        return DW'(32'h1000 + col * 32'h100 + int'(a));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < WH; i++) begin
            if (mem_rd_en[i]) mem_rd_data[i*DW +: DW] <= mem_val(i, mem_rd_addr[i*AW +: AW]);
            else              mem_rd_data[i*DW +: DW] <= DW'(16'hBAD0 + i);
        end
    end

    // Scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int rd_cnt, word_cnt, done_cnt, hold_cnt;
    int first_valid_cyc, last_hs_cyc, done_cyc;
    bit busy_seen, valid_seen, prev_stall;
    logic [EW-1:0] prev_word;

    always @(negedge clk) begin
        logic [EW-1:0] ew;
        logic [AW-1:0] ea;
        if (rst_n) begin
            if (mem_rd_en != '0) begin
                rd_cnt++;
                n_tests++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: addr=%h en=%b, no read expected", mem_rd_addr, mem_rd_en);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (mem_rd_en !== '1 || mem_rd_addr !== {WH{ea}}) begin
                        n_fail++;
                        $display("FAIL rd_addr: en=%b addr=%h, want en=1111 addr=%h", mem_rd_en, mem_rd_addr, {WH{ea}});
                    end
                end
            end
            if (out_valid) begin
                valid_seen = 1'b1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (prev_stall) begin
                hold_cnt++;
                n_tests++;
                if ({out_valid, out_last, out_col, out_data} !== {1'b1, prev_word}) begin
                    n_fail++;
                    $display("FAIL stall_hold: v=%b word=%h, want v=1 word=%h", out_valid, {out_last, out_col, out_data}, prev_word);
                end
            end
            if (out_valid && out_ready) begin
                word_cnt++;
                last_hs_cyc = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL word_unexpected: got %h, none expected", {out_last, out_col, out_data});
                end else begin
                    ew = exp_q.pop_front();
                    if ({out_last, out_col, out_data} !== ew) begin
                        n_fail++;
                        $display("FAIL word: got last/col/data=%h, want %h", {out_last, out_col, out_data}, ew);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_col, out_data};
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Driver tasks
    task automatic clear_stats();
        rd_cnt = 0; word_cnt = 0; done_cnt = 0; hold_cnt = 0;
        first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        busy_seen = 1'b0; valid_seen = 1'b0;
    endtask

    task automatic push_expect(input logic [AW-1:0] base, input int rows);
        logic [AW-1:0] a;
        for (int r = 0; r < rows; r++) begin
            a = AW'(int'(base) + r);
            exp_addr_q.push_back(a);
            for (int c = 0; c < WH; c++) begin
                exp_q.push_back({(r == rows - 1) && (c == WH - 1), CW'(c), mem_val(c, a)});
            end
        end
    endtask

    // Returns s = value of cyc during the cycle right after the accepting edge.
    task automatic issue_start(input logic [AW-1:0] base, input logic [AW:0] rows, output int s);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_rows = rows;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_col, out_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b en=%b addr=%h v=%b d=%h c=%h l=%b, want all 0",
                     busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_col, out_last);
        end
        n_tests++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d, want 0", dbg_state);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_row();
        int s; bit ok;
        clear_stats();
        out_ready = 1'b1;
        push_expect(8'h10, 1);
        issue_start(8'h10, 9'd1, s);
        wait_done(50, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: no done, want done"); end
        n_tests++;
        if (rd_cnt != 1 || word_cnt != 4) begin
            n_fail++;
            $display("FAIL single_counts: reads=%0d words=%0d, want 1 and 4", rd_cnt, word_cnt);
        end
        n_tests++;
        if (first_valid_cyc != s + 2) begin
            n_fail++;
            $display("FAIL single_latency: first valid at +%0d, want +2", first_valid_cyc - s);
        end
        n_tests++;
        if (last_hs_cyc != s + 5 || done_cyc != s + 6 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL single_done: last_hs +%0d done +%0d cnt %0d, want +5 +6 1",
                     last_hs_cyc - s, done_cyc - s, done_cnt);
        end
    endtask

    task automatic test_wrap();
        int s; bit ok;
        clear_stats();
        out_ready = 1'b1;
        push_expect(8'hFE, 3);
        issue_start(8'hFE, 9'd3, s);
        wait_done(100, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wrap_timeout: no done, want done"); end
        n_tests++;
        if (rd_cnt != 3 || word_cnt != 12 || exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_counts: reads=%0d words=%0d left=%0d/%0d, want 3 12 0/0",
                     rd_cnt, word_cnt, exp_q.size(), exp_addr_q.size());
        end
        n_tests++;
        if (done_cyc != s + 18) begin
            n_fail++;
            $display("FAIL wrap_timing: done at +%0d, want +18", done_cyc - s);
        end
    endtask

    task automatic test_backpressure();
        int s; bit ok;
        logic [6:0] pat;
        pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
        clear_stats();
        push_expect(8'h10, 1);
        issue_start(8'h10, 9'd1, s);
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 7; k++) begin
            out_ready = pat[k];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(20, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: no done, want done"); end
        n_tests++;
        if (rd_cnt != 1 || word_cnt != 4 || hold_cnt != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_counts: reads=%0d words=%0d holds=%0d left=%0d, want 1 4 3 0",
                     rd_cnt, word_cnt, hold_cnt, exp_q.size());
        end
        n_tests++;
        if (done_cyc != s + 9) begin
            n_fail++;
            $display("FAIL bp_done: done at +%0d, want +9", done_cyc - s);
        end
    endtask

    task automatic test_zero_rows();
        int s; bit ok;
        clear_stats();
        issue_start(8'h55, 9'd0, s);
        wait_done(10, ok);
        n_tests++;
        if (!ok || done_cyc != s || done_cnt != 1) begin
            n_fail++;
            $display("FAIL zero_done: ok=%b at +%0d cnt %0d, want 1 +0 1", ok, done_cyc - s, done_cnt);
        end
        n_tests++;
        if (rd_cnt != 0 || busy_seen || valid_seen) begin
            n_fail++;
            $display("FAIL zero_quiet: reads=%0d busy=%b valid=%b, want 0 0 0", rd_cnt, busy_seen, valid_seen);
        end
    endtask

    task automatic test_start_busy();
        int s; bit ok;
        clear_stats();
        out_ready = 1'b1;
        push_expect(8'h20, 2);
        issue_start(8'h20, 9'd2, s);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; base_addr = 8'h80; num_rows = 9'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, ok);
        repeat (4) begin @(posedge clk); #1; end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL busy_timeout: no done, want done"); end
        n_tests++;
        if (rd_cnt != 2 || word_cnt != 8 || done_cnt != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_ignore: reads=%0d words=%0d dones=%0d left=%0d, want 2 8 1 0",
                     rd_cnt, word_cnt, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int s; bit ok;
        clear_stats();
        out_ready = 1'b1;
        push_expect(8'h40, 2);
        issue_start(8'h40, 9'd2, s);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_col, out_last} !== '0
            || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b en=%b v=%b d=%h state=%0d, want all 0",
                     busy, done, mem_rd_en, out_valid, out_data, dbg_state);
        end
        exp_q.delete();
        exp_addr_q.delete();
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        n_tests++;
        if (done_cnt != 0 || rd_cnt != 1) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: dones=%0d reads=%0d, want 0 1", done_cnt, rd_cnt);
        end
        clear_stats();
        push_expect(8'h33, 1);
        issue_start(8'h33, 9'd1, s);
        wait_done(50, ok);
        n_tests++;
        if (!ok || rd_cnt != 1 || word_cnt != 4 || exp_q.size() != 0 || done_cyc != s + 6) begin
            n_fail++;
            $display("FAIL mid_reset_restart: ok=%b reads=%0d words=%0d left=%0d done +%0d, want 1 1 4 0 +6",
                     ok, rd_cnt, word_cnt, exp_q.size(), done_cyc - s);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_row();
        test_wrap();
        test_backpressure();
        test_zero_rows();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
